// File: rtl/dot_seq_pkg.sv
// Shared types and default sizing for the dot-product sequencer.
package dot_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_EMIT  = 2'd3
    } state_t;

    localparam int DEF_W = 16;
    localparam int DEF_C = 4;

endpackage

// File: rtl/dot_product_sequencer.sv
// Sequences one activation vector through a shared engine once per weight set.
// Optional macro DOT_PRODUCT_SEQUENCER_RELU_EN clamps stored results at zero.
module dot_product_sequencer
    import dot_seq_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int C  = DEF_C,
    localparam int SW = (C > 1) ? $clog2(C) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic signed [W-1:0]   in_a [0:3],
    input  logic                  in_v,
    output logic                  in_rdy,
    output logic signed [W-1:0]   eng_a [0:3],
    output logic                  eng_start,
    output logic [SW-1:0]         eng_sel,
    input  logic signed [2*W-1:0] eng_out,
    input  logic                  eng_done,
    output logic signed [2*W-1:0] out [0:C-1],
    output logic                  out_v,
    input  logic                  out_rdy,
    output logic                  err
);

    state_t                state_q, state_d;
    logic [SW-1:0]         ch_q, ch_d;
    logic signed [W-1:0]   eng_a_q [0:3];
    logic signed [W-1:0]   eng_a_d [0:3];
    logic                  eng_start_q, eng_start_d;
    logic [SW-1:0]         eng_sel_q, eng_sel_d;
    logic signed [2*W-1:0] out_q [0:C-1];
    logic signed [2*W-1:0] out_d [0:C-1];
    logic                  out_v_q, out_v_d;
    logic                  err_q, err_d;
    logic signed [2*W-1:0] result_s;

    // Value written into the result bank for the current channel
    always_comb begin
`ifdef DOT_PRODUCT_SEQUENCER_RELU_EN
        if (eng_out[2*W-1]) begin
            result_s = '0;
        end else begin
            result_s = eng_out;
        end
`else
        result_s = eng_out;
`endif
    end

    // Next-state logic for the sequencer FSM, counter and result bank
    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        eng_a_d     = eng_a_q;
        eng_start_d = 1'b0;
        eng_sel_d   = eng_sel_q;
        out_d       = out_q;
        out_v_d     = out_v_q;
        // A completion outside WAIT has no channel to land in; flag it.
        err_d       = err_q | (eng_done && (state_q != S_WAIT));

        case (state_q)
            S_IDLE: begin
                if (in_v) begin
                    eng_a_d     = in_a;
                    ch_d        = '0;
                    eng_sel_d   = '0;
                    eng_start_d = 1'b1;
                    state_d     = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (eng_done) begin
                    out_d[ch_q] = result_s;
                    if (ch_q == SW'(C - 1)) begin
                        out_v_d = 1'b1;
                        state_d = S_EMIT;
                    end else begin
                        ch_d        = ch_q + SW'(1);
                        eng_sel_d   = ch_q + SW'(1);
                        eng_start_d = 1'b1;
                        state_d     = S_ISSUE;
                    end
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_EMIT: begin
                if (out_rdy) begin
                    out_v_d = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_EMIT;
                end
            end
            default: begin
                state_d = S_IDLE;
                out_v_d = 1'b0;
            end
        endcase
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ch_q        <= '0;
            eng_start_q <= 1'b0;
            eng_sel_q   <= '0;
            out_v_q     <= 1'b0;
            err_q       <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                eng_a_q[i] <= '0;
            end
            for (int i = 0; i < C; i++) begin
                out_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            eng_start_q <= eng_start_d;
            eng_sel_q   <= eng_sel_d;
            out_v_q     <= out_v_d;
            err_q       <= err_d;
            eng_a_q     <= eng_a_d;
            out_q       <= out_d;
        end
    end

    assign in_rdy    = (state_q == S_IDLE);
    assign eng_a     = eng_a_q;
    assign eng_start = eng_start_q;
    assign eng_sel   = eng_sel_q;
    assign out       = out_q;
    assign out_v     = out_v_q;
    assign err       = err_q;

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Directed bench for dot_product_sequencer with an inline latency-4 engine model.
module tb_dot_product_sequencer;

    localparam int W = 16;
    localparam int C = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic signed [W-1:0]   in_a [0:3];
    logic                  in_v;
    logic                  in_rdy;
    logic signed [W-1:0]   eng_a [0:3];
    logic                  eng_start;
    logic [1:0]            eng_sel;
    logic signed [2*W-1:0] eng_out;
    logic                  eng_done;
    logic signed [2*W-1:0] out [0:C-1];
    logic                  out_v;
    logic                  out_rdy;
    logic                  err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int cyc_acc = 0;

    dot_product_sequencer #(.W(W), .C(C)) dut (
        .clk(clk), .rst(rst), .in_a(in_a), .in_v(in_v), .in_rdy(in_rdy),
        .eng_a(eng_a), .eng_start(eng_start), .eng_sel(eng_sel),
        .eng_out(eng_out), .eng_done(eng_done), .out(out), .out_v(out_v),
        .out_rdy(out_rdy), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic signed [W-1:0] a0, a1, a2, a3);
        chk("in_rdy_before", in_rdy, 1);
        in_a[0] = a0; in_a[1] = a1; in_a[2] = a2; in_a[3] = a3;
        in_v = 1'b1;
        tick();
        cyc_acc = cyc;
        in_v = 1'b0;
        chk("in_rdy_busy", in_rdy, 0);
        chk("eng_a0", eng_a[0], a0);
        chk("eng_a3", eng_a[3], a3);
    endtask

    task automatic wait_start();
        int n = 0;
        while (eng_start !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("start_seen", eng_start, 1);
    endtask

    // Engine takes the start pulse, then answers 4 cycles after sampling it.
    task automatic eng_channel(input int sel, input logic signed [2*W-1:0] val);
        wait_start();
        chk("eng_sel_issue", eng_sel, sel);
        tick();
        chk("start_one_cycle", eng_start, 0);
        chk("eng_sel_wait", eng_sel, sel);
        repeat (3) tick();
        eng_out  = val;
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        eng_out  = '0;
    endtask

    initial begin
        logic signed [2*W-1:0] exp_neg;
        rst = 1'b1; in_v = 1'b0; out_rdy = 1'b0; eng_done = 1'b0; eng_out = '0;
        for (int i = 0; i < 4; i++) in_a[i] = '0;
        repeat (2) tick();
        chk("rst_in_rdy", in_rdy, 1);
        chk("rst_start", eng_start, 0);
        chk("rst_sel", eng_sel, 0);
        chk("rst_out_v", out_v, 0);
        chk("rst_err", err, 0);
        chk("rst_out2", out[2], 0);
        chk("rst_eng_a1", eng_a[1], 0);
        rst = 1'b0;
        tick();

        // Job 1: basic sequencing, latency, one-cycle EMIT with out_rdy already high
        start_job(16'sd1, 16'sd2, 16'sd3, 16'sd4);
        out_rdy = 1'b1;
        for (int c = 0; c < C; c++) eng_channel(c, 32'sd1000 * (c + 1));
        chk("j1_out_v", out_v, 1);
        chk("j1_latency", cyc - cyc_acc + 1, 21);
        chk("j1_out0", out[0], 1000);
        chk("j1_out1", out[1], 2000);
        chk("j1_out2", out[2], 3000);
        chk("j1_out3", out[3], 4000);
        chk("j1_in_rdy_emit", in_rdy, 0);
        tick();
        chk("j1_out_v_drop", out_v, 0);
        chk("j1_in_rdy_back", in_rdy, 1);
        chk("j1_err", err, 0);
        out_rdy = 1'b0;

        // Job 2: negative result, backpressure held 10 cycles
        start_job(16'sd5, -16'sd6, 16'sd7, 16'sd8);
        eng_channel(0, 32'sd100);
        eng_channel(1, 32'sd200);
        eng_channel(2, -32'sd500);
        eng_channel(3, 32'sd400);
`ifdef DOT_PRODUCT_SEQUENCER_RELU_EN
        exp_neg = 32'sd0;
`else
        exp_neg = -32'sd500;
`endif
        for (int k = 0; k < 10; k++) begin
            in_v = 1'b1;
            chk("j2_hold_out_v", out_v, 1);
            chk("j2_hold_in_rdy", in_rdy, 0);
            chk("j2_hold_start", eng_start, 0);
            chk("j2_hold_out0", out[0], 100);
            chk("j2_hold_out2", out[2], exp_neg);
            chk("j2_hold_out3", out[3], 400);
            tick();
        end
        in_v = 1'b0;
        out_rdy = 1'b1;
        tick();
        chk("j2_out_v_drop", out_v, 0);
        chk("j2_in_rdy_back", in_rdy, 1);
        chk("j2_out1", out[1], 200);
        out_rdy = 1'b0;

        // Spurious completion in IDLE, then a clean job: err must stick
        eng_out = 32'sd77;
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        eng_out = '0;
        chk("spur_err", err, 1);
        chk("spur_out0", out[0], 100);
        start_job(16'sd1, 16'sd1, 16'sd1, 16'sd1);
        eng_channel(0, 32'sd11);
        eng_channel(1, 32'sd22);
        eng_channel(2, 32'sd33);
        eng_channel(3, -32'sd44);
        chk("j3_out0", out[0], 11);
        chk("j3_out3", out[3], -44);
        chk("j3_err_sticky", err, 1);
        out_rdy = 1'b1;
        tick();
        out_rdy = 1'b0;
        chk("j3_err_after", err, 1);

        // Reset clears err; then reset mid-WAIT on channel 1
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_err", err, 0);
        start_job(16'sd2, 16'sd2, 16'sd2, 16'sd2);
        eng_channel(0, 32'sd9);
        wait_start();
        chk("j4_sel1", eng_sel, 1);
        repeat (2) tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_in_rdy", in_rdy, 1);
        chk("mid_rst_sel", eng_sel, 0);
        chk("mid_rst_out0", out[0], 0);
        chk("mid_rst_eng_a0", eng_a[0], 0);
        chk("mid_rst_out_v", out_v, 0);
        tick();
        rst = 1'b0;
        tick();
        eng_out = 32'sd5;
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        eng_out = '0;
        chk("late_done_err", err, 1);
        chk("late_done_out1", out[1], 0);
        start_job(16'sd3, 16'sd3, 16'sd3, 16'sd3);
        for (int c = 0; c < C; c++) eng_channel(c, 32'sd7 + c);
        chk("j5_out_v", out_v, 1);
        chk("j5_out0", out[0], 7);
        chk("j5_out1", out[1], 8);
        chk("j5_out3", out[3], 10);
        out_rdy = 1'b1;
        tick();
        chk("j5_done_in_rdy", in_rdy, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dot_product_sequencer.md
DOT_PRODUCT_SEQUENCER -- requirements
Module: dot_product_sequencer

Interface
REQ-001 SHALL have parameter W, default 16, input element width (signed).
REQ-002 SHALL have parameter C, default 4, number of output channels (weight sets); legal range 1..16.
REQ-003 SHALL have localparam SW = max(1, clog2(C)), channel-select width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_a  input  signed W x [0:3]  activation vector.
REQ-007 in_v  input  1  in_a valid.
REQ-008 in_rdy  output  1  sequencer can accept in_a.
REQ-009 eng_a  output  signed W x [0:3]  latched activation vector to the shared engine.
REQ-010 eng_start  output  1  one-cycle engine start pulse.
REQ-011 eng_sel  output  SW  weight-set (channel) select to the engine.
REQ-012 eng_out  input  signed 2W  engine result.
REQ-013 eng_done  input  1  eng_out valid, one-cycle pulse.
REQ-014 out  output  signed 2W x [0:C-1]  per-channel results.
REQ-015 out_v  output  1  out valid.
REQ-016 out_rdy  input  1  downstream accepts out.
REQ-017 err  output  1  sticky protocol-error flag.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT, EMIT.
REQ-019 IDLE: in_rdy=1; on in_v: latch in_a into eng_a, clear channel counter ch to 0, go to ISSUE.
REQ-020 ISSUE: eng_start=1 for exactly one cycle, eng_sel=ch; go to WAIT next cycle.
REQ-021 WAIT: hold eng_sel and eng_a stable; on eng_done: store eng_out into out[ch]; if ch==C-1 go to EMIT, else ch<=ch+1 and go to ISSUE.
REQ-022 EMIT: out_v=1, out held stable; on out_rdy go to IDLE with out_v=0 the following cycle.
REQ-023 in_rdy SHALL be 0 in every state except IDLE; in_v outside IDLE is ignored.
REQ-024 Engine latency is unbounded; WAIT persists until eng_done.
REQ-025 Total latency for latency-L engine SHALL be C*(L+1)+1 cycles from in accept to out_v.
REQ-026 eng_done in IDLE, ISSUE or EMIT SHALL be ignored (no out update) and SHALL set err.
REQ-027 err SHALL be cleared only by rst.
REQ-028 out entries SHALL be stored at full 2W width, no truncation or rounding.
REQ-029 out_v with out_rdy already high in the EMIT entry cycle SHALL complete in that cycle (one-cycle EMIT).
REQ-030 Back-to-back: new in_v is accepted no earlier than the cycle after the EMIT handshake.

Reset
REQ-031 rst SHALL force IDLE, ch=0, in_rdy=1 (combinational from IDLE), eng_start=0, eng_sel=0, eng_a=0, out=all 0, out_v=0, err=0.
REQ-032 rst mid-operation SHALL abandon the job; a late eng_done afterward is handled per REQ-026.

Configuration
REQ-033 Macro DOT_PRODUCT_SEQUENCER_RELU_EN: when defined, result stored in out[ch] SHALL be max(eng_out, 0); when undefined, eng_out is stored unmodified.

Structure
REQ-034 Package dot_seq_pkg SHALL hold the FSM state typedef (2-bit enum) and default W and C constants.
REQ-035 No sub-module; single module with FSM, channel counter and result register bank.

Verification
REQ-036 W=16, C=4, bench engine latency 4 returning (sel+1)*1000: in_v with in_a={1,2,3,4} -> four eng_start pulses, eng_sel 0,1,2,3; out={1000,2000,3000,4000}, out_v at cycle 21 after accept.
REQ-037 Engine returns -500 on channel 2, RELU_EN undefined -> out[2]=-500; RELU_EN defined -> out[2]=0, others unchanged.
REQ-038 out_rdy held low 10 cycles in EMIT -> out_v and out stable all 10 cycles, in_rdy=0, in_v ignored; out_rdy high -> IDLE next cycle.
REQ-039 Spurious eng_done pulse in IDLE -> err=1, out unchanged; err stays 1 through a subsequent full correct job until rst.
REQ-040 rst asserted in WAIT for channel 1 -> all outputs zero immediately; late eng_done sets err; next job completes with correct results.
